// File: rtl/cnn_layer_accel_weight_seq_pkg.sv
// Shared types and constants for the CNN layer accelerator weight sequencer.
// Holds the FSM state type, the Gray-ordered phase codes and the Gray step function.
package cnn_layer_accel_weight_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_e;

  localparam int C_NUM_PHASES = 4;

  localparam logic [1:0] C_PH0 = 2'b00;
  localparam logic [1:0] C_PH1 = 2'b01;
  localparam logic [1:0] C_PH2 = 2'b11;
  localparam logic [1:0] C_PH3 = 2'b10;

  function automatic logic [1:0] gray_next(input logic [1:0] g);
    logic [1:0] n;
    case (g)
      C_PH0:   n = C_PH1;
      C_PH1:   n = C_PH2;
      C_PH2:   n = C_PH3;
      C_PH3:   n = C_PH0;
      default: n = C_PH0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_gray_cntr.sv
// 2-bit Gray phase stepper with synchronous clear, enable and terminal-count flag.
// Terminal count marks the last phase (2'b10) of a pass.
module cnn_layer_accel_gray_cntr
  import cnn_layer_accel_weight_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [1:0] gray,
  output logic       tc
);

  logic [1:0] gray_d;
  logic [1:0] gray_q;

  // Next phase: clear wins over step.
  always_comb begin
    gray_d = gray_q;
    if (clr) begin
      gray_d = C_PH0;
    end else if (en) begin
      gray_d = gray_next(gray_q);
    end else begin
      gray_d = gray_q;
    end
  end

  // Phase register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gray_q <= C_PH0;
    end else begin
      gray_q <= gray_d;
    end
  end

  assign gray = gray_q;
  assign tc   = (gray_q == C_PH3);

endmodule

// File: rtl/cnn_layer_accel_weight_sequencer.sv
// Weight sequence address generator: walks phases 00,01,11,10 x C_SEQ_LEN entries
// for num_passes passes, with stall/abort handling and a one-cycle done pulse.
module cnn_layer_accel_weight_sequencer
  import cnn_layer_accel_weight_seq_pkg::*;
#(
  parameter int C_SEQ_LEN    = 5,
  parameter int C_PASS_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    stall,
  input  logic [C_PASS_WIDTH-1:0] num_passes,
  output logic [1:0]              gray_code,
  output logic [2:0]              seq_data_addr,
  output logic                    seq_valid,
  output logic                    wht_valid,
  output logic                    busy,
  output logic                    done
);

  localparam logic [2:0]              C_ADDR_LAST = 3'(C_SEQ_LEN - 1);
  localparam logic [C_PASS_WIDTH-1:0] C_PASS_ONE  = C_PASS_WIDTH'(1);
  localparam logic [C_PASS_WIDTH-1:0] C_PASS_ZERO = '0;

  seq_state_e              state_d, state_q;
  logic [2:0]              addr_d, addr_q;
  logic [C_PASS_WIDTH-1:0] pass_d, pass_q;
  logic [C_PASS_WIDTH-1:0] npass_d, npass_q;
  logic                    seq_valid_d, seq_valid_q;
  logic                    wht_valid_d, wht_valid_q;
  logic                    busy_d, busy_q;
  logic                    done_d, done_q;
  logic                    ph_clr_s, ph_en_s, ph_tc_s;
  logic [1:0]              ph_s;
  logic                    final_s;

  cnn_layer_accel_gray_cntr u_gray_cntr (
    .clk  (clk),
    .rst  (rst),
    .clr  (ph_clr_s),
    .en   (ph_en_s),
    .gray (ph_s),
    .tc   (ph_tc_s)
  );

  // Every position held in RUN has already been issued, so the last one ends the run.
  assign final_s = ph_tc_s && (addr_q == C_ADDR_LAST) && (pass_q == (npass_q - C_PASS_ONE));

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pass_d      = pass_q;
    npass_d     = npass_q;
    seq_valid_d = 1'b0;
    done_d      = 1'b0;
    ph_clr_s    = 1'b0;
    ph_en_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          npass_d  = num_passes;
          pass_d   = C_PASS_ZERO;
          addr_d   = 3'd0;
          ph_clr_s = 1'b1;
          if (num_passes == C_PASS_ZERO) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = RUN;
            seq_valid_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (final_s) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (stall) begin
          state_d = RUN;
        end else begin
          seq_valid_d = 1'b1;
          if (addr_q == C_ADDR_LAST) begin
            addr_d  = 3'd0;
            ph_en_s = 1'b1;
            if (ph_tc_s) begin
              pass_d = pass_q + C_PASS_ONE;
            end else begin
              pass_d = pass_q;
            end
          end else begin
            addr_d = addr_q + 3'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d      = (state_d != IDLE);
    wht_valid_d = seq_valid_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= 3'd0;
      pass_q      <= C_PASS_ZERO;
      npass_q     <= C_PASS_ZERO;
      seq_valid_q <= 1'b0;
      wht_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pass_q      <= pass_d;
      npass_q     <= npass_d;
      seq_valid_q <= seq_valid_d;
      wht_valid_q <= wht_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign gray_code     = ph_s;
  assign seq_data_addr = addr_q;
  assign seq_valid     = seq_valid_q;
  assign wht_valid     = wht_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequencer.sv
// Scoreboard bench for the weight sequencer: expected beats are queued at start
// and popped by a negedge monitor; scenario checks cover stall, abort and reset.
module tb_cnn_layer_accel_weight_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       stall;
  logic [7:0] num_passes;
  logic [1:0] gray_code;
  logic [2:0] seq_data_addr;
  logic       seq_valid;
  logic       wht_valid;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;
  int beats    = 0;

  logic [4:0] exp_q[$];
  logic       mon_en       = 1'b0;
  logic       prev_sv      = 1'b0;
  logic       exp_done_nxt = 1'b0;
  logic       zero_pending = 1'b0;

  cnn_layer_accel_weight_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .stall         (stall),
    .num_passes    (num_passes),
    .gray_code     (gray_code),
    .seq_data_addr (seq_data_addr),
    .seq_valid     (seq_valid),
    .wht_valid     (wht_valid),
    .busy          (busy),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] phase_code(input int ph);
    logic [1:0] tbl [4];
    tbl[0] = 2'b00; tbl[1] = 2'b01; tbl[2] = 2'b11; tbl[3] = 2'b10;
    return tbl[ph];
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic exp_d;
    logic [4:0] e;
    if (mon_en) begin
      exp_d        = exp_done_nxt;
      exp_done_nxt = 1'b0;
      if (zero_pending) begin
        exp_done_nxt = 1'b1;
        zero_pending = 1'b0;
      end
      check_eq("wht_valid", wht_valid, prev_sv);
      check_eq("done", done, exp_d);
      if (done) check_eq("busy_in_done", busy, 1'b1);
      if (seq_valid) begin
        check_eq("busy_in_beat", busy, 1'b1);
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", {gray_code, seq_data_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("beat", {gray_code, seq_data_addr}, e);
          beats++;
          if (exp_q.size() == 0) exp_done_nxt = 1'b1;
        end
      end
      prev_sv = seq_valid;
    end
  end

  task automatic do_start(input logic [7:0] np);
    @(posedge clk); #1;
    beats      = 0;
    num_passes = np;
    start      = 1'b1;
    if (np == 8'd0) zero_pending = 1'b1;
    for (int p = 0; p < int'(np); p++)
      for (int ph = 0; ph < 4; ph++)
        for (int a = 0; a < 5; a++)
          exp_q.push_back({phase_code(ph), 3'(a)});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int i = 0;
    while (beats < n && i < budget) begin
      @(negedge clk); #1;
      i++;
    end
    if (beats < n) check_eq("beat_wait", beats, n);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #2;
      if (done) seen = 1'b1;
    end
    check_eq("done_seen", seen, 1'b1);
    check_eq("queue_empty", exp_q.size(), 0);
    @(posedge clk); #2;
    check_eq("busy_after", busy, 1'b0);
  endtask

  initial begin
    bit seen;
    rst = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0; num_passes = 8'd0;
    #12;
    check_eq("reset_outputs", {gray_code, seq_data_addr, seq_valid, wht_valid, busy, done}, 10'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; mon_en = 1'b1;

    // One pass, no stall; first beat one cycle after start is sampled.
    do_start(8'd1);
    #1;
    check_eq("first_beat_latency", {seq_valid, gray_code, seq_data_addr}, {1'b1, 2'b00, 3'd0});
    wait_done(40);
    check_eq("beats_1pass", beats, 20);

    // Zero passes: done straight away, busy for that single cycle.
    do_start(8'd0);
    #1;
    check_eq("zero_done", {done, busy, seq_valid}, {1'b1, 1'b1, 1'b0});
    @(posedge clk); #2;
    check_eq("zero_after", {done, busy}, 2'b00);

    // Two passes with a 3-cycle stall right after beat 01/2.
    do_start(8'd2);
    wait_beats(8, 50);
    stall = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      check_eq("stall_hold", {seq_valid, gray_code, seq_data_addr}, {1'b0, 2'b01, 3'd2});
    end
    stall = 1'b0;
    wait_done(80);
    check_eq("beats_2pass", beats, 40);

    // Second start mid-run must be ignored.
    do_start(8'd1);
    wait_beats(10, 50);
    num_passes = 8'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(60);
    check_eq("beats_ignored_start", beats, 20);

    // Stall straddling the final beat defers it.
    do_start(8'd1);
    wait_beats(19, 50);
    stall = 1'b1;
    repeat (2) begin
      @(posedge clk); #2;
      check_eq("final_defer", {seq_valid, done}, 2'b00);
    end
    stall = 1'b0;
    wait_done(20);

    // Abort after 7 beats; address holds at the 7th beat (01/1).
    do_start(8'd1);
    wait_beats(7, 50);
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    check_eq("abort_state", {seq_valid, done, busy}, 3'b000);
    check_eq("abort_addr", {gray_code, seq_data_addr}, {2'b01, 3'd1});
    exp_q.delete();
    repeat (4) @(posedge clk);
    #2; check_eq("abort_idle", {seq_valid, busy}, 2'b00);
    do_start(8'd1);
    wait_done(40);
    check_eq("beats_after_abort", beats, 20);

    // Asynchronous reset between edges at beat 12.
    do_start(8'd1);
    wait_beats(12, 50);
    #2;
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    check_eq("async_reset", {gray_code, seq_data_addr, seq_valid, wht_valid, busy, done}, 10'd0);
    exp_q.delete();
    prev_sv = 1'b0; exp_done_nxt = 1'b0; zero_pending = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; mon_en = 1'b1;
    repeat (5) @(posedge clk);
    #2; check_eq("post_reset_idle", {seq_valid, busy, done}, 3'b000);

    // Three passes under random stall.
    do_start(8'd3);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      stall = ($urandom_range(3, 0) == 0);
      #1;
      if (done) seen = 1'b1;
    end
    stall = 1'b0;
    check_eq("rand_done_seen", seen, 1'b1);
    check_eq("rand_beats", beats, 60);
    @(posedge clk); #2;
    check_eq("rand_busy_after", busy, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
